// File: rtl/sdram_arbiter_if.sv
// Signal bundle between the video/CPU/DMA requesters, the slot arbiter and the SDRAM controller port.
// The arbiter connects through the slave modport; the surrounding system uses the master modport.
interface sdram_arbiter_if;
    logic        vid_req;
    logic [23:0] vid_addr;
    logic        vid_ack;
    logic [63:0] vid_dout64;

    logic        cpu_req;
    logic        cpu_we;
    logic [23:0] cpu_addr;
    logic [1:0]  cpu_ds;
    logic [15:0] cpu_din;
    logic        cpu_ack;
    logic [15:0] cpu_dout;

    logic        dma_req;
    logic        dma_we;
    logic [23:0] dma_addr;
    logic [1:0]  dma_ds;
    logic [15:0] dma_din;
    logic        dma_ack;
    logic [15:0] dma_dout;

    logic        mem_req;
    logic        mem_we;
    logic [23:0] mem_addr;
    logic [1:0]  mem_ds;
    logic [15:0] mem_din;
    logic [15:0] mem_dout;
    logic [63:0] mem_dout64;

    logic [1:0]  grant_id;

    modport slave (
        input  vid_req, vid_addr,
        input  cpu_req, cpu_we, cpu_addr, cpu_ds, cpu_din,
        input  dma_req, dma_we, dma_addr, dma_ds, dma_din,
        input  mem_dout, mem_dout64,
        output vid_ack, vid_dout64,
        output cpu_ack, cpu_dout,
        output dma_ack, dma_dout,
        output mem_req, mem_we, mem_addr, mem_ds, mem_din,
        output grant_id
    );

    modport master (
        output vid_req, vid_addr,
        output cpu_req, cpu_we, cpu_addr, cpu_ds, cpu_din,
        output dma_req, dma_we, dma_addr, dma_ds, dma_din,
        output mem_dout, mem_dout64,
        input  vid_ack, vid_dout64,
        input  cpu_ack, cpu_dout,
        input  dma_ack, dma_dout,
        input  mem_req, mem_we, mem_addr, mem_ds, mem_din,
        input  grant_id
    );
endinterface

// File: rtl/sdram_arbiter.sv
// Slot arbiter: one SDRAM access per 12-cycle slot of clk_96, shared between video, CPU and DMA,
// with a video run limit, CPU/DMA round-robin and a forced idle (refresh) slot after long bursts.
module sdram_arbiter #(
    parameter int GRANT_PHASE   = 11,
    parameter int DATA_PHASE    = 10,
    parameter int VID_MAX       = 3,
    parameter int REFRESH_EVERY = 16
) (
    input  logic           clk_96,
    input  logic           reset,
    input  logic           clk_8_en,
    sdram_arbiter_if.slave bus
);
    localparam int VW = $clog2(VID_MAX + 1);
    localparam int BW = $clog2(REFRESH_EVERY + 1);

    localparam logic [1:0] ID_IDLE = 2'd0;
    localparam logic [1:0] ID_VID  = 2'd1;
    localparam logic [1:0] ID_CPU  = 2'd2;
    localparam logic [1:0] ID_DMA  = 2'd3;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t        state;
    logic [3:0]    ph;
    logic          en_d;
    logic          en_rise;
    logic [VW-1:0] vid_run;
    logic [BW-1:0] burst;
    logic          ptr_dma;

    logic grant_slot;
    logic data_slot;
    logic pick_vid;
    logic pick_dma;

    assign grant_slot = (ph == 4'(GRANT_PHASE));
    assign data_slot  = (ph == 4'(DATA_PHASE));
    assign pick_vid   = bus.vid_req && ((vid_run < VW'(VID_MAX)) || !(bus.cpu_req || bus.dma_req));
    assign pick_dma   = bus.dma_req && (!bus.cpu_req || ptr_dma);

    // Capture/ack is handled before arbitration so that, when both phases coincide,
    // a fresh grant in the same cycle overrides the mem_req drop and the return to IDLE.
    always_ff @(posedge clk_96) begin
        if (reset) begin
            ph             <= '0;
            en_d           <= 1'b0;
            en_rise        <= 1'b0;
            state          <= IDLE;
            vid_run        <= '0;
            burst          <= '0;
            ptr_dma        <= 1'b0;
            bus.mem_req    <= 1'b0;
            bus.mem_we     <= 1'b0;
            bus.mem_addr   <= '0;
            bus.mem_ds     <= '0;
            bus.mem_din    <= '0;
            bus.grant_id   <= ID_IDLE;
            bus.vid_ack    <= 1'b0;
            bus.cpu_ack    <= 1'b0;
            bus.dma_ack    <= 1'b0;
            bus.vid_dout64 <= '0;
            bus.cpu_dout   <= '0;
            bus.dma_dout   <= '0;
        end else begin
            en_d    <= clk_8_en;
            en_rise <= clk_8_en & ~en_d;
            if (en_rise || ph == 4'd11) begin
                ph <= '0;
            end else begin
                ph <= ph + 4'd1;
            end

            bus.vid_ack <= 1'b0;
            bus.cpu_ack <= 1'b0;
            bus.dma_ack <= 1'b0;

            if (state == BUSY && data_slot) begin
                case (bus.grant_id)
                    ID_VID: begin
                        bus.vid_ack    <= 1'b1;
                        bus.vid_dout64 <= bus.mem_dout64;
                    end
                    ID_CPU: begin
                        bus.cpu_ack <= 1'b1;
                        if (!bus.mem_we) bus.cpu_dout <= bus.mem_dout;
                    end
                    ID_DMA: begin
                        bus.dma_ack <= 1'b1;
                        if (!bus.mem_we) bus.dma_dout <= bus.mem_dout;
                    end
                    default: ;
                endcase
                bus.mem_req <= 1'b0;
                state       <= IDLE;
            end

            if (grant_slot && (state == IDLE || data_slot)) begin
                if (burst == BW'(REFRESH_EVERY)) begin
                    bus.mem_req  <= 1'b0;
                    bus.grant_id <= ID_IDLE;
                    burst        <= '0;
                end else if (pick_vid) begin
                    bus.mem_req  <= 1'b1;
                    bus.mem_we   <= 1'b0;
                    bus.mem_addr <= bus.vid_addr;
                    bus.mem_ds   <= 2'b11;
                    bus.mem_din  <= '0;
                    bus.grant_id <= ID_VID;
                    if (vid_run < VW'(VID_MAX)) vid_run <= vid_run + VW'(1);
                    burst        <= burst + BW'(1);
                    state        <= BUSY;
                end else if (bus.cpu_req || bus.dma_req) begin
                    if (pick_dma) begin
                        bus.mem_we   <= bus.dma_we;
                        bus.mem_addr <= bus.dma_addr;
                        bus.mem_ds   <= bus.dma_ds;
                        bus.mem_din  <= bus.dma_din;
                        bus.grant_id <= ID_DMA;
                    end else begin
                        bus.mem_we   <= bus.cpu_we;
                        bus.mem_addr <= bus.cpu_addr;
                        bus.mem_ds   <= bus.cpu_ds;
                        bus.mem_din  <= bus.cpu_din;
                        bus.grant_id <= ID_CPU;
                    end
                    if (bus.cpu_req && bus.dma_req) ptr_dma <= ~ptr_dma;
                    bus.mem_req <= 1'b1;
                    vid_run     <= '0;
                    burst       <= burst + BW'(1);
                    state       <= BUSY;
                end else begin
                    bus.mem_req  <= 1'b0;
                    bus.grant_id <= ID_IDLE;
                    burst        <= '0;
                    vid_run      <= '0;
                end
            end
        end
    end
endmodule

// File: tb/tb_sdram_arbiter.sv
// Bench for sdram_arbiter: directed scenarios plus random requester traffic, each slot checked
// against a slot-level arbitration model kept in plain integers.
`timescale 1ns/1ps
module tb_sdram_arbiter;
    localparam int GP   = 11;
    localparam int DP   = 10;
    localparam int VMAX = 3;
    localparam int REF  = 16;
    localparam int LAT  = ((DP - GP + 11) % 12) + 1;

    logic clk_96 = 1'b0;
    logic reset;
    logic clk_8_en;

    sdram_arbiter_if bus();

    sdram_arbiter #(.GRANT_PHASE(GP), .DATA_PHASE(DP), .VID_MAX(VMAX), .REFRESH_EVERY(REF)) dut (
        .clk_96  (clk_96),
        .reset   (reset),
        .clk_8_en(clk_8_en),
        .bus     (bus.slave)
    );

    always #5 clk_96 = ~clk_96;

    int errors = 0;
    int checks = 0;

    // Slot phase = cycles since the last reset or resync point, modulo 12.
    int cyc = 0;
    int zero_at = 0;
    bit pend = 0;
    bit prev_en = 0;
    always @(posedge clk_96) begin
        cyc++;
        if (reset) begin
            zero_at = cyc;
            pend    = 0;
            prev_en = 0;
        end else begin
            if (pend) zero_at = cyc;
            pend    = clk_8_en && !prev_en;
            prev_en = clk_8_en;
        end
    end

    function automatic int mph();
        return (cyc - zero_at) % 12;
    endfunction

    int m_vrun, m_burst;
    bit m_ptr_dma;
    logic [15:0] exp_cpu_dout, exp_dma_dout;
    logic [63:0] exp_vid64;
    bit drop_vid, drop_cpu, drop_dma;

    function automatic logic [144:0] out_vec();
        return {bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_ds, bus.mem_din, bus.grant_id,
                bus.vid_ack, bus.cpu_ack, bus.dma_ack, bus.vid_dout64, bus.cpu_dout, bus.dma_dout};
    endfunction

    task automatic model_reset();
        m_vrun = 0;
        m_burst = 0;
        m_ptr_dma = 0;
        exp_cpu_dout = '0;
        exp_dma_dout = '0;
        exp_vid64 = '0;
    endtask

    task automatic wait_grant_phase();
        int guard = 0;
        while (mph() != GP && guard < 30) begin
            @(negedge clk_96);
            guard++;
        end
    endtask

    // One full slot: predict the winner from the sampled requests, then check grant, command and ack.
    task automatic run_slot(input logic [15:0] rd16, input logic [63:0] rd64, output int obs);
        int gid, early;
        logic c, d, v, ewe;
        logic [23:0] ea;
        logic [1:0] eds;
        logic [15:0] edin;
        logic [2:0] eack;
        obs = -1;
        wait_grant_phase();
        c = bus.cpu_req;
        d = bus.dma_req;
        v = bus.vid_req;
        gid = 0; ewe = 0; ea = '0; eds = '0; edin = '0;
        if (m_burst == REF) begin
            m_burst = 0;
        end else if (v && (m_vrun < VMAX || !(c || d))) begin
            gid = 1;
            if (m_vrun < VMAX) m_vrun++;
            ea = bus.vid_addr;
            eds = 2'b11;
        end else if (c || d) begin
            if (c && d) begin
                gid = m_ptr_dma ? 3 : 2;
                m_ptr_dma = !m_ptr_dma;
            end else begin
                gid = c ? 2 : 3;
            end
            m_vrun = 0;
        end else begin
            m_burst = 0;
            m_vrun = 0;
        end
        if (gid == 2) begin ewe = bus.cpu_we; ea = bus.cpu_addr; eds = bus.cpu_ds; edin = bus.cpu_din; end
        if (gid == 3) begin ewe = bus.dma_we; ea = bus.dma_addr; eds = bus.dma_ds; edin = bus.dma_din; end
        if (gid != 0) m_burst++;

        @(negedge clk_96);
        obs = int'(bus.grant_id);
        checks++;
        if (bus.grant_id !== 2'(gid)) begin
            errors++; $display("[TB] FAIL grant_id: got %0d expected %0d", bus.grant_id, gid);
        end
        checks++;
        if (bus.mem_req !== (gid != 0)) begin
            errors++; $display("[TB] FAIL mem_req: got %b expected %b", bus.mem_req, gid != 0);
        end
        checks++;
        if ({bus.vid_ack, bus.cpu_ack, bus.dma_ack} !== 3'b000) begin
            errors++; $display("[TB] FAIL ack_width: got %b expected 000", {bus.vid_ack, bus.cpu_ack, bus.dma_ack});
        end
        if (gid == 0) return;
        checks++;
        if ({bus.mem_we, bus.mem_addr, bus.mem_ds} !== {ewe, ea, eds}) begin
            errors++; $display("[TB] FAIL mem_cmd: got we=%b addr=%h ds=%b expected we=%b addr=%h ds=%b",
                               bus.mem_we, bus.mem_addr, bus.mem_ds, ewe, ea, eds);
        end
        if (ewe) begin
            checks++;
            if (bus.mem_din !== edin) begin
                errors++; $display("[TB] FAIL mem_din: got %h expected %h", bus.mem_din, edin);
            end
        end
        bus.mem_dout = rd16;
        bus.mem_dout64 = rd64;
        early = 0;
        for (int i = 1; i < LAT; i++) begin
            @(negedge clk_96);
            if ({bus.vid_ack, bus.cpu_ack, bus.dma_ack} != 3'b000) early++;
        end
        checks++;
        if (early != 0) begin
            errors++; $display("[TB] FAIL ack_early: got %0d early acks expected 0", early);
        end
        @(negedge clk_96);
        eack = 3'b100 >> (gid - 1);
        checks++;
        if ({bus.vid_ack, bus.cpu_ack, bus.dma_ack} !== eack) begin
            errors++; $display("[TB] FAIL ack: got %b expected %b", {bus.vid_ack, bus.cpu_ack, bus.dma_ack}, eack);
        end
        checks++;
        if (bus.mem_req !== 1'b0 || bus.grant_id !== 2'(gid)) begin
            errors++; $display("[TB] FAIL ack_bus: got req=%b id=%0d expected req=0 id=%0d", bus.mem_req, bus.grant_id, gid);
        end
        checks++;
        case (gid)
            1: begin
                exp_vid64 = rd64;
                if (bus.vid_dout64 !== exp_vid64) begin
                    errors++; $display("[TB] FAIL vid_dout64: got %h expected %h", bus.vid_dout64, exp_vid64);
                end
                if (drop_vid) bus.vid_req = 0;
            end
            2: begin
                if (!ewe) exp_cpu_dout = rd16;
                if (bus.cpu_dout !== exp_cpu_dout) begin
                    errors++; $display("[TB] FAIL cpu_dout: got %h expected %h", bus.cpu_dout, exp_cpu_dout);
                end
                if (drop_cpu) bus.cpu_req = 0;
            end
            default: begin
                if (!ewe) exp_dma_dout = rd16;
                if (bus.dma_dout !== exp_dma_dout) begin
                    errors++; $display("[TB] FAIL dma_dout: got %h expected %h", bus.dma_dout, exp_dma_dout);
                end
                if (drop_dma) bus.dma_req = 0;
            end
        endcase
    endtask

    task automatic test_reset();
        reset = 1; clk_8_en = 0;
        bus.vid_req = 0; bus.vid_addr = '0;
        bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_addr = '0; bus.cpu_ds = '0; bus.cpu_din = '0;
        bus.dma_req = 0; bus.dma_we = 0; bus.dma_addr = '0; bus.dma_ds = '0; bus.dma_din = '0;
        bus.mem_dout = '0; bus.mem_dout64 = '0;
        repeat (2) @(negedge clk_96);
        checks++;
        if (out_vec() !== '0) begin
            errors++; $display("[TB] FAIL reset_outputs: got %h expected 0", out_vec());
        end
        reset = 0;
        model_reset();
    endtask

    task automatic test_cpu_read();
        int g;
        test_reset();
        drop_cpu = 1;
        bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 24'h000123; bus.cpu_ds = 2'b11;
        run_slot(16'hBEEF, 64'h0, g);
        checks++;
        if (g != 2) begin errors++; $display("[TB] FAIL cpu_read_owner: got %0d expected 2", g); end
        run_slot(16'h0, 64'h0, g);
        checks++;
        if (g != 0) begin errors++; $display("[TB] FAIL idle_after_read: got %0d expected 0", g); end
    endtask

    task automatic test_cpu_write();
        int g;
        drop_cpu = 1;
        bus.cpu_req = 1; bus.cpu_we = 1; bus.cpu_addr = 24'($urandom); bus.cpu_ds = 2'b01; bus.cpu_din = 16'h55AA;
        run_slot(16'h1357, 64'h0, g);
        checks++;
        if (bus.cpu_dout !== 16'hBEEF) begin
            errors++; $display("[TB] FAIL write_keeps_dout: got %h expected BEEF", bus.cpu_dout);
        end
    endtask

    task automatic test_cpu_dma_rr();
        int g;
        test_reset();
        drop_cpu = 0; drop_dma = 0;
        bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 24'h111111; bus.cpu_ds = 2'b11;
        bus.dma_req = 1; bus.dma_we = 1; bus.dma_addr = 24'h222222; bus.dma_ds = 2'b10; bus.dma_din = 16'hA5A5;
        for (int i = 0; i < 6; i++) begin
            run_slot(16'($urandom), 64'h0, g);
            checks++;
            if (g != ((i % 2) ? 3 : 2)) begin
                errors++; $display("[TB] FAIL rr_slot%0d: got %0d expected %0d", i, g, (i % 2) ? 3 : 2);
            end
        end
    endtask

    task automatic test_all_three();
        int g;
        int pat[8] = '{1, 1, 1, 2, 1, 1, 1, 3};
        test_reset();
        drop_vid = 0; drop_cpu = 0; drop_dma = 0;
        bus.vid_req = 1; bus.vid_addr = 24'h0ABCDE;
        bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 24'h000010; bus.cpu_ds = 2'b11;
        bus.dma_req = 1; bus.dma_we = 0; bus.dma_addr = 24'h000020; bus.dma_ds = 2'b11;
        for (int i = 0; i < 12; i++) begin
            run_slot(16'($urandom), {$urandom, $urandom}, g);
            checks++;
            if (g != pat[i % 8]) begin
                errors++; $display("[TB] FAIL mix_slot%0d: got %0d expected %0d", i, g, pat[i % 8]);
            end
        end
    endtask

    task automatic test_refresh();
        int g;
        test_reset();
        drop_vid = 0;
        bus.vid_req = 1; bus.vid_addr = 24'h345678;
        for (int i = 0; i < 20; i++) begin
            run_slot(16'h0, {$urandom, $urandom}, g);
            checks++;
            if (g != ((i == REF) ? 0 : 1)) begin
                errors++; $display("[TB] FAIL refresh_slot%0d: got %0d expected %0d", i, g, (i == REF) ? 0 : 1);
            end
        end
    endtask

    task automatic test_reset_busy();
        int g, seen;
        test_reset();
        drop_cpu = 1; drop_vid = 1;
        bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 24'h00CAFE; bus.cpu_ds = 2'b11;
        wait_grant_phase();
        @(negedge clk_96);
        bus.mem_dout = 16'h1234;
        repeat (4) @(negedge clk_96);
        reset = 1;
        @(negedge clk_96);
        checks++;
        if (out_vec() !== '0) begin
            errors++; $display("[TB] FAIL reset_busy_outputs: got %h expected 0", out_vec());
        end
        reset = 0;
        model_reset();
        bus.vid_req = 1; bus.vid_addr = 24'h000777;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk_96);
            if (bus.cpu_ack) seen++;
        end
        checks++;
        if (seen != 0) begin errors++; $display("[TB] FAIL abandoned_ack: got %0d acks expected 0", seen); end
        run_slot(16'h0, {$urandom, $urandom}, g);
        checks++;
        if (g != 1) begin errors++; $display("[TB] FAIL post_reset_owner: got %0d expected 1", g); end
    endtask

    task automatic test_random();
        int g;
        test_reset();
        drop_vid = 1; drop_cpu = 1; drop_dma = 1;
        for (int s = 0; s < 40; s++) begin
            if (!bus.vid_req && $urandom_range(0, 1) == 1) begin
                bus.vid_req = 1; bus.vid_addr = 24'($urandom);
            end
            if (!bus.cpu_req && $urandom_range(0, 1) == 1) begin
                bus.cpu_req = 1; bus.cpu_we = 1'($urandom); bus.cpu_addr = 24'($urandom);
                bus.cpu_ds = 2'($urandom); bus.cpu_din = 16'($urandom);
            end
            if (!bus.dma_req && $urandom_range(0, 1) == 1) begin
                bus.dma_req = 1; bus.dma_we = 1'($urandom); bus.dma_addr = 24'($urandom);
                bus.dma_ds = 2'($urandom); bus.dma_din = 16'($urandom);
            end
            run_slot(16'($urandom), {$urandom, $urandom}, g);
        end
    endtask

    task automatic test_resync();
        int g, early;
        bit done, at_data;
        test_reset();
        drop_cpu = 1; drop_dma = 1;
        bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 24'h0F0F0F; bus.cpu_ds = 2'b11;
        wait_grant_phase();
        @(negedge clk_96);
        m_burst = 1;
        checks++;
        if (bus.grant_id !== 2'd2 || bus.mem_req !== 1'b1) begin
            errors++; $display("[TB] FAIL resync_grant: got req=%b id=%0d expected req=1 id=2", bus.mem_req, bus.grant_id);
        end
        bus.mem_dout = 16'h6E6E;
        done = 0; early = 0;
        for (int i = 0; i < 30 && !done; i++) begin
            if (i == 2) clk_8_en = 1;
            if (i == 5) clk_8_en = 0;
            at_data = (mph() == DP);
            @(negedge clk_96);
            if (at_data) done = 1;
            else if (bus.cpu_ack) early++;
        end
        checks++;
        if (!done || bus.cpu_ack !== 1'b1 || early != 0) begin
            errors++; $display("[TB] FAIL resync_ack: got ack=%b early=%0d reached=%0d expected ack=1 early=0 reached=1",
                               bus.cpu_ack, early, done);
        end
        checks++;
        if (bus.cpu_dout !== 16'h6E6E) begin
            errors++; $display("[TB] FAIL resync_dout: got %h expected 6E6E", bus.cpu_dout);
        end
        exp_cpu_dout = 16'h6E6E;
        bus.cpu_req = 0;
        bus.dma_req = 1; bus.dma_we = 0; bus.dma_addr = 24'h00D00D; bus.dma_ds = 2'b11;
        run_slot(16'($urandom), 64'h0, g);
    endtask

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        drop_vid = 0; drop_cpu = 0; drop_dma = 0;
        test_reset();
        test_cpu_read();
        test_cpu_write();
        test_cpu_dma_rr();
        test_all_three();
        test_refresh();
        test_reset_busy();
        test_random();
        test_resync();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
